// File: rtl/cnt_pkg.sv
// cnt_pkg: shared direction encoding and load-clamp helper for updown_cnt_mod.
package cnt_pkg;
  localparam logic CNT_DIR_UP = 1'b1;
  localparam logic CNT_DIR_DN = 1'b0;
  function automatic logic [63:0] cnt_clamp(input logic [63:0] v, input logic [63:0] m);
    return (v >= m) ? m - 64'd1 : v;
  endfunction
endpackage

// File: rtl/updown_cnt_mod_tcell.sv
// tcell_sync: 1-bit toggle cell with async active-low reset and direct-load override.
module tcell_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic force_en,
  input  logic force_val,
  output logic q,
  output logic qb
);
  logic q_q, q_d;
  always_comb q_d = force_en ? force_val : q_q ^ t;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  assign q  = q_q;
  assign qb = ~q_q;
endmodule

// File: rtl/updown_cnt_mod.sv
// updown_cnt_mod: synchronous modulo-N up/down counter from toggle cells.
// Define UPDOWN_CNT_SAT_EN to saturate at the range ends instead of wrapping.
module updown_cnt_mod
  import cnt_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
  logic [WIDTH-1:0] step, t, frc_val, ld_val;
  logic             bnd, frc, wrap_d, wrap_q;
  always_comb begin
    step   = (up == CNT_DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
    ld_val = WIDTH'(cnt_clamp(64'(din), 64'(MODULUS)));
    tc     = (up == CNT_DIR_UP) ? (q == MAX) : (q == '0);
    bnd    = en & tc;
`ifdef UPDOWN_CNT_SAT_EN
    frc     = load;
    frc_val = ld_val;
    t       = (en & !bnd & !load) ? q ^ step : '0;
    wrap_d  = 1'b0;
`else
    // crossing a modulus boundary loads the wrap target directly into the cells
    frc     = load | bnd;
    frc_val = load ? ld_val : ((up == CNT_DIR_UP) ? '0 : MAX);
    t       = (en & !load) ? q ^ step : '0;
    wrap_d  = !load & bnd;
`endif
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tcell_sync #(.RST_VAL(RST_V[i])) u_cell (
      .clk(clk), .rst(rst), .t(t[i]), .force_en(frc), .force_val(frc_val[i]),
      .q(q[i]), .qb(qb[i])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_updown_cnt_mod.sv
module tb_updown_cnt_mod;
`ifdef UPDOWN_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, up = 1'b0, load = 1'b0, en16 = 1'b0, en10 = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] q16, qb16, q10, qb10;
  logic tc16, wrap16, tc10, wrap10;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  updown_cnt_mod #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) d16 (
    .clk(clk), .rst(rst), .en(en16), .up(up), .load(load), .din(din),
    .q(q16), .qb(qb16), .tc(tc16), .wrap(wrap16));
  updown_cnt_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) d10 (
    .clk(clk), .rst(rst), .en(en10), .up(up), .load(load), .din(din),
    .q(q10), .qb(qb10), .tc(tc10), .wrap(wrap10));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int e;
    #3;
    chk("rst_q16", q16, 0); chk("rst_qb16", qb16, 4'hF); chk("rst_wrap16", wrap16, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    en16 = 1'b1; up = 1'b0;
    #1 chk("t1_tc_at0", tc16, 1);
    tick(); chk("t1_q_a", q16, SAT ? 0 : 15); chk("t1_wrap_a", wrap16, SAT ? 0 : 1);
    chk("t1_qb_a", qb16, SAT ? 4'hF : 4'h0);
    tick(); chk("t1_q_b", q16, SAT ? 0 : 14); chk("t1_wrap_b", wrap16, 0);
    tick(); chk("t1_q_c", q16, SAT ? 0 : 13); chk("t1_qb_c", qb16, SAT ? 4'hF : 4'h2);
    en16 = 1'b0; up = 1'b1; en10 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (k <= 9) ? k : (SAT ? 9 : k - 10);
      chk("t2_q", q10, e);
      chk("t2_tc", tc10, e == 9);
      chk("t2_wrap", wrap10, !SAT && k == 10);
    end
    load = 1'b1; din = 4'd12; up = 1'b0;
    tick(); chk("t3_clamp", q10, 9); chk("t3_wrap", wrap10, 0); chk("t3_q16", q16, 12);
    din = 4'd15;
    tick(); chk("t3_clamp15", q10, 9);
    din = 4'd6;
    tick(); chk("t4_ld6", q10, 6);
    load = 1'b0; up = 1'b1;
    tick(); chk("t4_q7", q10, 7);
    #2 rst = 1'b0;
    #1 chk("t4_rst_q", q10, 0); chk("t4_rst_qb", qb10, 4'hF); chk("t4_rst_wrap", wrap10, 0);
    chk("t4_rst_q16", q16, 0);
    #2 rst = 1'b1;
    tick(); chk("t4_resume", q10, 1);
    load = 1'b1; din = 4'd5; en10 = 1'b0;
    tick(); chk("t5_ld", q10, 5);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      up = k[0];
      tick();
      chk("t5_hold", q10, 5); chk("t5_tc", tc10, 0); chk("t5_wrap", wrap10, 0);
    end
    load = 1'b1; din = 4'd0;
    tick(); load = 1'b0; en10 = 1'b1; up = 1'b0;
    tick(); chk("dn_wrap_q", q10, SAT ? 0 : 9); chk("dn_wrap_w", wrap10, !SAT);
    up = 1'b1;
    tick(); chk("alt_wrap_q", q10, SAT ? 1 : 0); chk("alt_wrap_w", wrap10, !SAT);
    en10 = 1'b0; load = 1'b1; din = 4'd14;
    tick(); chk("t6_ld", q16, 14);
    load = 1'b0; en16 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = SAT ? 15 : (k == 1 ? 15 : k - 2);
      chk("t6_q", q16, e);
      chk("t6_tc", tc16, e == 15);
      chk("t6_wrap", wrap16, !SAT && k == 2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
